// File: rtl/tmma_sequencer_pkg.sv
// Shared definitions for the tmma sequencer: instruction types, array op
// encodings, sequencer FSM states, bus widths and the type->op decode helper.
// Latency: n/a (declarations only). Backpressure: n/a.
package tmma_sequencer_pkg;

  localparam int ADDR_WIDTH           = 32;
  localparam int TINST_TYPE_WIDTH     = 3;
  localparam int TLOAD_DATAW_WIDTH    = 4;  // one-hot element size in bytes
  localparam int TMMA_PRECISION_WIDTH = 3;

  // Issued tmma-queue instruction types; codes 4..7 are unassigned.
  typedef enum logic [TINST_TYPE_WIDTH-1:0] {
    TINST_PRELOADA   = 3'd0,
    TINST_PRELOADC   = 3'd1,
    TINST_TMMA       = 3'd2,
    TINST_POSTSTOREC = 3'd3
  } tinst_type_e;

  // Command opcodes presented to the systolic array.
  typedef enum logic [1:0] {
    ARR_LOAD_A  = 2'd0,
    ARR_LOAD_C  = 2'd1,
    ARR_COMPUTE = 2'd2,
    ARR_DRAIN_C = 2'd3
  } array_op_e;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEQ  = 2'd1,
    ST_WAIT = 2'd2
  } seq_state_e;

  // Everything the sequencer needs to know about an instruction type.
  typedef struct packed {
    logic      known;       // type is one the array understands
    array_op_e op;          // array opcode to emit on every row
    logic      use_addr1;   // base comes from addr1 instead of addr0
    logic      needs_done;  // wait for array_done before retiring
  } op_map_t;

  function automatic op_map_t map_type(input logic [TINST_TYPE_WIDTH-1:0] t);
    op_map_t m;
    m = '{known: 1'b0, op: ARR_LOAD_A, use_addr1: 1'b0, needs_done: 1'b0};
    case (t)
      TINST_PRELOADA:   m = '{known: 1'b1, op: ARR_LOAD_A,  use_addr1: 1'b0, needs_done: 1'b0};
      TINST_PRELOADC:   m = '{known: 1'b1, op: ARR_LOAD_C,  use_addr1: 1'b0, needs_done: 1'b0};
      TINST_TMMA:       m = '{known: 1'b1, op: ARR_COMPUTE, use_addr1: 1'b0, needs_done: 1'b1};
      TINST_POSTSTOREC: m = '{known: 1'b1, op: ARR_DRAIN_C, use_addr1: 1'b1, needs_done: 1'b1};
      default:          m = '{known: 1'b0, op: ARR_LOAD_A,  use_addr1: 1'b0, needs_done: 1'b0};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tmma_sequencer_if.sv
// Issue-side and array-side bus of the tmma sequencer.
// Latency: n/a (wires only). Backpressure: issue valid/ready, array cmd vld/rdy.
// Ports: issue_tmma_* (instruction in), array_cmd_* (row command out),
//        array_done_i (compute/drain finished). slave = sequencer, master = environment.
interface tmma_sequencer_if #(
  parameter int ARRAY_DIM = 4
) ();
  import tmma_sequencer_pkg::*;

  localparam int ROW_W = $clog2(ARRAY_DIM);

  logic                            issue_tmma_valid_i;
  logic                            issue_tmma_ready_o;
  logic [TINST_TYPE_WIDTH-1:0]     issue_tmma_type_i;
  logic [TLOAD_DATAW_WIDTH-1:0]    issue_tmma_data_width_i;
  logic [ADDR_WIDTH-1:0]           issue_tmma_addr0_i;
  logic [ADDR_WIDTH-1:0]           issue_tmma_addr1_i;
  logic [TMMA_PRECISION_WIDTH-1:0] issue_tmma_precision_i;
  logic                            issue_tmma_acc_i;

  logic                            array_cmd_vld_o;
  logic                            array_cmd_rdy_i;
  logic [1:0]                      array_cmd_op_o;
  logic [ROW_W-1:0]                array_cmd_row_o;
  logic [ADDR_WIDTH-1:0]           array_cmd_addr_o;
  logic [TMMA_PRECISION_WIDTH-1:0] array_cmd_precision_o;
  logic                            array_cmd_acc_o;
  logic                            array_done_i;

  modport slave (
    input  issue_tmma_valid_i, issue_tmma_type_i, issue_tmma_data_width_i,
           issue_tmma_addr0_i, issue_tmma_addr1_i, issue_tmma_precision_i,
           issue_tmma_acc_i, array_cmd_rdy_i, array_done_i,
    output issue_tmma_ready_o, array_cmd_vld_o, array_cmd_op_o, array_cmd_row_o,
           array_cmd_addr_o, array_cmd_precision_o, array_cmd_acc_o
  );

  modport master (
    output issue_tmma_valid_i, issue_tmma_type_i, issue_tmma_data_width_i,
           issue_tmma_addr0_i, issue_tmma_addr1_i, issue_tmma_precision_i,
           issue_tmma_acc_i, array_cmd_rdy_i, array_done_i,
    input  issue_tmma_ready_o, array_cmd_vld_o, array_cmd_op_o, array_cmd_row_o,
           array_cmd_addr_o, array_cmd_precision_o, array_cmd_acc_o
  );

endinterface

// File: rtl/tmma_sequencer.sv
// Expands one tmma instruction into ARRAY_DIM row commands for the systolic array.
// Latency: first command 1 cycle after issue; ready again 1 cycle after last handshake / done.
// Backpressure: command outputs hold while array_cmd_rdy_i is low; issue ready only when idle.
// Ports: clk, rst_n (async active-low), bus (tmma_sequencer_if.slave),
//        busy_o (not idle), inst_cnt_o (retired instruction count, wraps).
module tmma_sequencer
  import tmma_sequencer_pkg::*;
#(
  parameter int ARRAY_DIM = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tmma_sequencer_if.slave        bus,
  output logic                   busy_o,
  output logic [31:0]            inst_cnt_o
);

  localparam int                ROW_W    = $clog2(ARRAY_DIM);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ARRAY_DIM - 1);

  seq_state_e                      state_q;
  logic [ROW_W-1:0]                row_q;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic [ADDR_WIDTH-1:0]           stride_q;
  array_op_e                       op_q;
  logic                            needs_done_q;
  logic [TMMA_PRECISION_WIDTH-1:0] prec_q;
  logic                            acc_q;
  logic                            vld_q;
  logic [31:0]                     cnt_q;

  op_map_t                         map_d;
  logic [ADDR_WIDTH-1:0]           base_d;
  logic [ADDR_WIDTH-1:0]           stride_d;
  logic [ADDR_WIDTH-1:0]           addr_d;
  logic [ROW_W-1:0]                row_d;

  always_comb begin
    map_d    = map_type(bus.issue_tmma_type_i);
    base_d   = map_d.use_addr1 ? bus.issue_tmma_addr1_i : bus.issue_tmma_addr0_i;
    // One row of elements is ARRAY_DIM elements of data_width bytes each.
    stride_d = ADDR_WIDTH'(bus.issue_tmma_data_width_i) * ADDR_WIDTH'(ARRAY_DIM);
    // Address accumulator: natural 2^ADDR_WIDTH wrap is the intended behaviour.
    addr_d   = addr_q + stride_q;
    row_d    = row_q + ROW_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      row_q        <= '0;
      addr_q       <= '0;
      stride_q     <= '0;
      op_q         <= ARR_LOAD_A;
      needs_done_q <= 1'b0;
      prec_q       <= '0;
      acc_q        <= 1'b0;
      vld_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.issue_tmma_valid_i) begin
            op_q         <= map_d.op;
            needs_done_q <= map_d.needs_done;
            addr_q       <= base_d;
            stride_q     <= stride_d;
            prec_q       <= bus.issue_tmma_precision_i;
            acc_q        <= bus.issue_tmma_acc_i;
            row_q        <= '0;
            // Unknown types still pass through SEQ for one cycle, but with
            // no command valid, so they are consumed without reaching the array.
            vld_q        <= map_d.known;
            state_q      <= ST_SEQ;
          end
        end
        ST_SEQ: begin
          if (!vld_q) begin
            state_q <= ST_IDLE;
          end else if (bus.array_cmd_rdy_i) begin
            row_q  <= row_d;   // wraps to 0 after the last row
            addr_q <= addr_d;
            if (row_q == LAST_ROW) begin
              vld_q <= 1'b0;
              if (needs_done_q) begin
                state_q <= ST_WAIT;
              end else begin
                state_q <= ST_IDLE;
                cnt_q   <= cnt_q + 32'd1;
              end
            end
          end
        end
        ST_WAIT: begin
          if (bus.array_done_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= cnt_q + 32'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.issue_tmma_ready_o    = (state_q == ST_IDLE);
  assign bus.array_cmd_vld_o       = vld_q;
  assign bus.array_cmd_op_o        = op_q;
  assign bus.array_cmd_row_o       = row_q;
  assign bus.array_cmd_addr_o      = addr_q;
  assign bus.array_cmd_precision_o = prec_q;
  assign bus.array_cmd_acc_o       = acc_q;
  assign busy_o                    = (state_q != ST_IDLE);
  assign inst_cnt_o                = cnt_q;

endmodule
